bias_sat_pipe: RTL

- Parametrised successor to the 8x8-bit bias adder: adds a per-lane signed bias to each lane of a systolic-array output vector, then saturates each lane to a signed OUT_W range.
- Sits between the systolic array drain and the activation/writeback stage.
- Generalised in lane count and widths.
- Holds a small bank of bias vectors, selectable per input vector.
- Two-stage valid/ready pipeline with backpressure.
- Sticky saturation counter for debug/statistics.

---
 rtl/bias_sat_pipe.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/bias_sat_pipe.sv
// bias_sat_pipe
//   Adds a per-lane signed bias (chosen from a small bias bank) to each lane of
//   an input vector, then saturates every lane to a signed OUT_W range.
//   Two-stage valid/ready pipeline: stage 1 registers the widened sums,
//   stage 2 clamps and holds the output. A sticky counter accumulates
//   the number of lanes that were clamped.
//
// Optional feature: define BIAS_SAT_PIPE_RELU_EN to add the relu_en input.
//   relu_en travels with its vector; when set, lanes whose clamped result is
//   negative are output as zero.
//
// Ports
//   clk, rst               rising-edge clock, synchronous active-high reset
//   bias_we/waddr/wdata    bias bank write port (takes effect next cycle)
//   in_valid/in_ready      input handshake
//   in_data, in_bsel       input lanes (lane i at [IN_W*i +: IN_W]), bank select
//   relu_en                (optional) zero negative results for this vector
//   out_valid/out_ready    output handshake
//   out_data               saturated lanes (lane i at [OUT_W*i +: OUT_W])
//   clr_count, sat_count   clamp statistics counter and its clear
module bias_sat_pipe #(
  parameter int LANES      = 8,
  parameter int IN_W       = 8,
  parameter int OUT_W      = 8,
  parameter int BIAS_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          bias_we,
  input  logic [$clog2(BIAS_DEPTH)-1:0] bias_waddr,
  input  logic [LANES*IN_W-1:0]         bias_wdata,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES*IN_W-1:0]         in_data,
  input  logic [$clog2(BIAS_DEPTH)-1:0] in_bsel,
`ifdef BIAS_SAT_PIPE_RELU_EN
  input  logic                          relu_en,
`endif
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES*OUT_W-1:0]        out_data,
  input  logic                          clr_count,
  output logic [CNT_W-1:0]              sat_count
);

  localparam int SUM_W = IN_W + 1;
  localparam int CLW   = $clog2(LANES + 1);
  // Bounds expressed at sum width; when OUT_W == SUM_W they equal the sum's
  // own range, so the compares below can never fire.
  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(-(1 << (OUT_W - 1)));

  // Bias bank: cleared by reset, so it is a register array rather than RAM.
  // Read is combinational on in_bsel, so a same-cycle write sees the old entry.
  logic [LANES*IN_W-1:0] bank_reg [BIAS_DEPTH];
  logic [LANES*IN_W-1:0] bias_rd;

  logic                             s1_valid_reg;
  logic                             s1_relu_reg;
  logic [LANES-1:0][SUM_W-1:0]      sum_reg;
  logic [LANES-1:0][SUM_W-1:0]      sum_next;
  logic                             out_valid_reg;
  logic [LANES*OUT_W-1:0]           out_data_reg;
  logic [CNT_W-1:0]                 sat_count_reg;

  logic                             s2_adv;
  logic                             in_fire;
  logic                             relu_in;
  logic [LANES-1:0][OUT_W-1:0]      lane_sat;
  logic [LANES-1:0][OUT_W-1:0]      lane_raw;
  logic [LANES-1:0]                 lane_clamp;
  logic [CLW-1:0]                   clamp_cnt;
  logic [CNT_W:0]                   sat_sum;
  logic [CNT_W-1:0]                 sat_next;

  assign bias_rd  = bank_reg[in_bsel];
  assign s2_adv   = !out_valid_reg || out_ready;
  assign in_ready = !s1_valid_reg || s2_adv;
  assign in_fire  = in_valid && in_ready;

`ifdef BIAS_SAT_PIPE_RELU_EN
  assign relu_in = relu_en;
`else
  assign relu_in = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BIAS_DEPTH; i++) begin
        bank_reg[i] <= '0;
      end
    end else if (bias_we) begin
      bank_reg[bias_waddr] <= bias_wdata;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [IN_W-1:0]         din;
      logic [IN_W-1:0]         bin;
      logic signed [SUM_W-1:0] s;
      logic                    hi;
      logic                    lo;

      assign din = in_data[IN_W*gi +: IN_W];
      assign bin = bias_rd[IN_W*gi +: IN_W];
      // One extra bit of headroom: the sum of two IN_W values cannot overflow.
      assign sum_next[gi] = {din[IN_W-1], din} + {bin[IN_W-1], bin};

      assign s  = sum_reg[gi];
      assign hi = s > SAT_MAX;
      assign lo = s < SAT_MIN;
      assign lane_clamp[gi] = hi | lo;
      assign lane_raw[gi]   = s[OUT_W-1:0];

      always_comb begin
        lane_sat[gi] = s[OUT_W-1:0];
        if (hi) begin
          lane_sat[gi] = SAT_MAX[OUT_W-1:0];
        end else if (lo) begin
          lane_sat[gi] = SAT_MIN[OUT_W-1:0];
        end
        // Clamping preserves sign, so the clamped result is negative exactly
        // when the raw sum is.
        if (s1_relu_reg && s[SUM_W-1]) begin
          lane_sat[gi] = '0;
        end
      end
    end
  endgenerate

  always_comb begin
    clamp_cnt = '0;
    for (int i = 0; i < LANES; i++) begin
      clamp_cnt = clamp_cnt + CLW'(lane_clamp[i]);
    end
  end

  assign sat_sum  = {1'b0, sat_count_reg} + (CNT_W + 1)'(clamp_cnt);
  assign sat_next = sat_sum[CNT_W] ? '1 : sat_sum[CNT_W-1:0];

  // Stage 1: widened sums
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_relu_reg  <= 1'b0;
      sum_reg      <= '0;
    end else if (in_fire) begin
      s1_valid_reg <= 1'b1;
      s1_relu_reg  <= relu_in;
      sum_reg      <= sum_next;
    end else if (s2_adv) begin
      s1_valid_reg <= 1'b0;
    end
  end

  // Stage 2: clamp, output hold, statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      sat_count_reg <= '0;
    end else begin
      if (s2_adv) begin
        out_valid_reg <= s1_valid_reg;
        out_data_reg  <= s1_valid_reg ? lane_sat : lane_raw;
      end
      if (clr_count) begin
        sat_count_reg <= '0;
      end else if (s2_adv && s1_valid_reg) begin
        sat_count_reg <= sat_next;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign sat_count = sat_count_reg;

endmodule
